mdu: RTL

//   Multiply/divide unit in the EX stage, directly downstream of the register file.

---
 rtl/mdu_pkg.sv | 34 +++
 rtl/mdu_divider.sv | 42 ++++
 rtl/mdu.sv | 121 ++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states
// and small op-classification helpers used by the datapath and control.
package mdu_pkg;

   typedef enum logic [2:0] {
      MDU_MULT  = 3'd0,
      MDU_MULTU = 3'd1,
      MDU_DIV   = 3'd2,
      MDU_DIVU  = 3'd3,
      MDU_MTHI  = 3'd4,
      MDU_MTLO  = 3'd5
   } mdu_op_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } mdu_state_t;

   // Ops 0..3 are the multi-cycle multiply/divide group
   function automatic logic is_muldiv(input logic [2:0] op);
      return (op[2] == 1'b0);
   endfunction

   // Ops 0..1 are the multiplies
   function automatic logic is_mult(input logic [2:0] op);
      return (op[2:1] == 2'b00);
   endfunction

   // Even encodings within the mult/div group are the signed variants
   function automatic logic is_signed_op(input logic [2:0] op);
      return (op == MDU_MULT) || (op == MDU_DIV);
   endfunction

endpackage

// File: rtl/mdu_divider.sv
// Combinational signed/unsigned divider. Signed division truncates toward
// zero and the remainder follows the dividend's sign. The most-negative /
// -1 case falls out of the magnitude arithmetic as quotient 0x80..0,
// remainder 0. A zero divisor is flagged so the caller can skip the commit.
module mdu_divider
   import mdu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   input  logic             is_signed,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_zero
);

   logic             neg_a;
   logic             neg_b;
   logic [WIDTH-1:0] mag_a;
   logic [WIDTH-1:0] mag_b;
   logic [WIDTH-1:0] uq;
   logic [WIDTH-1:0] ur;

   // Divide magnitudes unsigned, then restore the signs
   always_comb begin
      neg_a     = is_signed & dividend[WIDTH-1];
      neg_b     = is_signed & divisor[WIDTH-1];
      mag_a     = neg_a ? -dividend : dividend;
      mag_b     = neg_b ? -divisor : divisor;
      div_zero  = (divisor == '0);
      uq        = '0;
      ur        = '0;
      if (!div_zero) begin
         uq = mag_a / mag_b;
         ur = mag_a % mag_b;
      end
      quotient  = (neg_a ^ neg_b) ? -uq : uq;
      remainder = neg_a ? -ur : ur;
   end

endmodule

// File: rtl/mdu.sv
// EX-stage multiply/divide unit owning the HI/LO registers. Mult/div ops
// latch their operands, hold busy for a fixed number of cycles and then
// commit the result with a one-cycle done pulse. MTHI/MTLO write directly
// when idle. cancel aborts anything in flight without touching HI/LO.
module mdu
   import mdu_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cancel,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
   localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
   localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

   mdu_state_t         state;
   logic [CNT_W-1:0]   cnt;
   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   b_q;
   logic [2:0]         op_q;

   logic               signed_op;
   logic [2*WIDTH-1:0] ext_a;
   logic [2*WIDTH-1:0] ext_b;
   logic [2*WIDTH-1:0] product;
   logic [WIDTH-1:0]   quotient;
   logic [WIDTH-1:0]   remainder;
   logic               div_zero;

   // Full-width product of the latched operands, sign- or zero-extended
   always_comb begin
      signed_op = is_signed_op(op_q);
      ext_a     = {{WIDTH{signed_op & a_q[WIDTH-1]}}, a_q};
      ext_b     = {{WIDTH{signed_op & b_q[WIDTH-1]}}, b_q};
      product   = ext_a * ext_b;
   end

   mdu_divider #(
      .WIDTH(WIDTH)
   ) u_divider (
      .dividend (a_q),
      .divisor  (b_q),
      .is_signed(signed_op),
      .quotient (quotient),
      .remainder(remainder),
      .div_zero (div_zero)
   );

   // Control FSM, latency counter and the HI/LO registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_IDLE;
         cnt   <= '0;
         a_q   <= '0;
         b_q   <= '0;
         op_q  <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         hi    <= '0;
         lo    <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start && !cancel) begin
                  if (is_muldiv(op)) begin
                     a_q   <= a;
                     b_q   <= b;
                     op_q  <= op;
                     cnt   <= is_mult(op) ? MULT_LOAD : DIV_LOAD;
                     busy  <= 1'b1;
                     state <= ST_BUSY;
                  end else if (op == MDU_MTHI) begin
                     hi <= a;
                  end else if (op == MDU_MTLO) begin
                     lo <= a;
                  end
               end
            end
            ST_BUSY: begin
               if (cancel) begin
                  cnt   <= '0;
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end else if (cnt == '0) begin
                  if (is_mult(op_q)) begin
                     {hi, lo} <= product;
                  end else if (!div_zero) begin
                     hi <= remainder;
                     lo <= quotient;
                  end
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
